uart_tx_feeder: RTL and testbench

Byte-stream source that sits directly upstream of the UART top level and drives its external transmit port (`datain_ext`, `new_in`). User logic pushes bytes into a 16-entry FIFO at any rate. The feeder then issues the bytes to the UART one at a time, with a fixed inter-byte gap, so the UART interface never receives a byte while the previous one is still being serialized. It also records FIFO overflow and UART error events as sticky flags.

---
 rtl/uart_tx_feeder.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: 16-entry byte FIFO that paces bytes into the UART top level.
// Each byte is presented on datain_ext with a one-cycle new_in strobe, and the
// next strobe is held off for a fixed number of clocks so the UART is never
// handed a byte while it is still shifting out the previous one.
module uart_tx_feeder #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int GAP_CYCLES = 104167,
  parameter int CNT_W      = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              clear,
  input  logic              uart_error,
  output logic [7:0]        datain_ext,
  output logic              new_in,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              err_seen
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Occupancy value that means "full", in the width of the count register.
  localparam logic [ADDR_W:0]  L_FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]  L_COUNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] L_PTR_ONE   = ADDR_W'(1);
  // The ISSUE cycle and the final IDLE cycle account for two clocks of the gap,
  // so the counter only has to cover the remainder.
  localparam logic [CNT_W-1:0] L_GAP_RELOAD = CNT_W'(GAP_CYCLES - 2);
  localparam logic [CNT_W-1:0] L_GAP_ONE    = CNT_W'(1);
  localparam bit               L_SKIP_GAP   = (GAP_CYCLES <= 2);

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  state_t            r_state;
  logic [CNT_W-1:0]  r_gap;
  logic [7:0]        r_datain;
  logic              r_new_in;
  logic              r_overflow;
  logic              r_err_seen;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full  = (r_count == L_FULL_COUNT);
  assign w_empty = (r_count == '0);

  // The only pop is the IDLE->ISSUE transition; clear suppresses it.
  assign w_pop  = (r_state == IDLE) && !w_empty && !clear;
  // A push into a full FIFO still fits if the head leaves in the same cycle.
  assign w_push = wr_en && !clear && (!w_full || w_pop);
  // Writes swallowed by clear are intentional and do not count as overflow.
  assign w_drop = wr_en && !clear && !w_push;

  assign datain_ext = r_datain;
  assign new_in     = r_new_in;
  assign full       = w_full;
  assign empty      = w_empty;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign err_seen   = r_err_seen;

  // Storage array: written on accepted pushes only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is 2**ADDR_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + L_COUNT_ONE;
        2'b01:   r_count <= r_count - L_COUNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue FSM: pop a byte, strobe it for one cycle, then wait out the gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_gap    <= '0;
      r_datain <= '0;
      r_new_in <= 1'b0;
    end else if (clear) begin
      r_state  <= IDLE;
      r_gap    <= '0;
      r_new_in <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_new_in <= 1'b0;
          if (!w_empty) begin
            r_datain <= r_mem[r_rd_ptr];
            r_new_in <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_new_in <= 1'b0;
          r_gap    <= L_GAP_RELOAD;
          if (L_SKIP_GAP) begin
            r_state <= IDLE;
          end else begin
            r_state <= GAP;
          end
        end
        GAP: begin
          r_new_in <= 1'b0;
          if (uart_error) begin
            r_gap <= L_GAP_RELOAD;
          end else if (r_gap <= L_GAP_ONE) begin
            r_gap   <= '0;
            r_state <= IDLE;
          end else begin
            r_gap <= r_gap - L_GAP_ONE;
          end
        end
        default: begin
          r_new_in <= 1'b0;
          r_gap    <= '0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  // Sticky status flags, cleared only by reset or clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_err_seen <= 1'b0;
    end else if (clear) begin
      r_overflow <= 1'b0;
      r_err_seen <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (uart_error) begin
        r_err_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed stimulus with a strobe scoreboard. Every byte the
// bench expects on the UART side is queued together with the cycle its strobe
// should appear in; a negedge monitor pops and compares on each new_in.
module tb_uart_tx_feeder;

  localparam int GAP = 20;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clear;
  logic       uart_error;
  logic [7:0] datain_ext;
  logic       new_in;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       err_seen;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sbQ[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  uart_tx_feeder #(
    .DEPTH(16),
    .ADDR_W(4),
    .GAP_CYCLES(GAP),
    .CNT_W(17)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .clear(clear),
    .uart_error(uart_error),
    .datain_ext(datain_ext),
    .new_in(new_in),
    .full(full),
    .empty(empty),
    .count(count),
    .overflow(overflow),
    .err_seen(err_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle number: cycle N is the period that starts at the N-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the head of the scoreboard in data and timing.
  always @(negedge clk) begin
    if (!rst && new_in) begin
      if (sbQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_strobe cycle=%0d data=%0h required=no strobe", cyc, datain_ext);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        total++;
        if (datain_ext !== e.data) begin
          bad++;
          $display("[TB] FAIL strobe_data cycle=%0d actual=%0h required=%0h", cyc, datain_ext, e.data);
        end
        total++;
        if (cyc != e.cyc) begin
          bad++;
          $display("[TB] FAIL strobe_cycle data=%0h actual=%0d required=%0d", e.data, cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleUntil(input int n);
    while (cyc < n) tick();
  endtask

  task automatic expectByte(input logic [7:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    sbQ.push_back(e);
  endtask

  // Holds the given inputs for the current cycle, then releases wr_en/clear.
  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic c, input logic e);
    wr_en      = w;
    wr_data    = d;
    clear      = c;
    uart_error = e;
    tick();
    wr_en = 1'b0;
    clear = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, actual, expected);
    end
  endtask

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    clear      = 1'b0;
    uart_error = 1'b0;
    tick();

    checkOutput("rst_datain", int'(datain_ext), 0);
    checkOutput("rst_new_in", int'(new_in), 0);
    checkOutput("rst_count", int'(count), 0);
    checkOutput("rst_empty", int'(empty), 1);
    checkOutput("rst_full", int'(full), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    checkOutput("rst_err_seen", int'(err_seen), 0);
    tick();
    tick();
    rst = 1'b0;

    // Single byte: push at 10, strobe at 12.
    idleUntil(10);
    expectByte(8'hA5, 12);
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    checkOutput("t1_count_after_push", int'(count), 1);
    checkOutput("t1_empty_after_push", int'(empty), 0);
    tick();
    checkOutput("t1_empty_after_pop", int'(empty), 1);

    // Burst of five: strobes GAP apart starting two cycles after the first push.
    idleUntil(40);
    for (int i = 0; i < 5; i++) begin
      expectByte(8'(i + 1), 42 + GAP * i);
      applyStimulus(1'b1, 8'(i + 1), 1'b0, 1'b0);
    end
    checkOutput("t2_count_peak", int'(count), 4);
    idleUntil(130);
    checkOutput("t2_count_drained", int'(count), 0);
    checkOutput("t2_empty_drained", int'(empty), 1);

    // Overflow under a stalled gap: error held from 145 to 169.
    idleUntil(140);
    expectByte(8'h10, 142);
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
    idleUntil(145);
    uart_error = 1'b1;
    idleUntil(146);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) expectByte(8'(8'h20 + i), 189 + GAP * i);
      applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b1);
      if (i == 15) begin
        checkOutput("t3_full_at_16", int'(full), 1);
        checkOutput("t3_no_overflow_yet", int'(overflow), 0);
      end
    end
    checkOutput("t3_count_full", int'(count), 16);
    checkOutput("t3_overflow", int'(overflow), 1);
    checkOutput("t3_err_seen", int'(err_seen), 1);
    idleUntil(170);
    uart_error = 1'b0;
    idleUntil(495);
    checkOutput("t3_count_drained", int'(count), 0);
    checkOutput("t3_overflow_sticky", int'(overflow), 1);

    // Bare clear wipes the sticky flags.
    idleUntil(500);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("clr_overflow", int'(overflow), 0);
    checkOutput("clr_err_seen", int'(err_seen), 0);

    // Fill to 16 with the feeder running, then push during the pop cycle 531.
    idleUntil(510);
    for (int i = 0; i < 17; i++) begin
      expectByte(8'(8'h40 + i), 512 + GAP * i);
      applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    end
    checkOutput("t4_count_full", int'(count), 16);
    checkOutput("t4_full", int'(full), 1);
    idleUntil(531);
    expectByte(8'h77, 512 + GAP * 17);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    checkOutput("t4_count_stays_full", int'(count), 16);
    checkOutput("t4_no_overflow", int'(overflow), 0);
    idleUntil(860);
    checkOutput("t4_count_drained", int'(count), 0);

    // One-cycle error 10 cycles after a strobe at 902 pushes the next to 932.
    idleUntil(900);
    expectByte(8'h88, 902);
    applyStimulus(1'b1, 8'h88, 1'b0, 1'b0);
    idleUntil(903);
    expectByte(8'h99, 932);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    idleUntil(912);
    checkOutput("t5_err_before", int'(err_seen), 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    uart_error = 1'b0;
    checkOutput("t5_err_seen", int'(err_seen), 1);

    // Clear with three bytes queued plus a simultaneous write of 0x55.
    idleUntil(960);
    expectByte(8'hB1, 962);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'(8'hB1 + i), 1'b0, 1'b0);
    end
    checkOutput("t6_count_before", int'(count), 3);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    checkOutput("t6_count", int'(count), 0);
    checkOutput("t6_empty", int'(empty), 1);
    checkOutput("t6_overflow", int'(overflow), 0);
    checkOutput("t6_err_seen", int'(err_seen), 0);
    checkOutput("t6_new_in", int'(new_in), 0);
    idleUntil(1060);
    checkOutput("t6_count_end", int'(count), 0);
    checkOutput("sb_leftover", sbQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
